ipm_serial_masker: RTL and testbench

- Serial inner-product masker. It converts an unmasked 128-bit plaintext into 16 IPM-encoded bytes of v shares each, one byte per cycle.
- It is the inverse of the serial unmasking stage on the cipher output, and it feeds the masked plaintext port of the IPM AES round core.
- Share relation per byte: S = XOR over i of L_i·R_i in GF(2^8), reduction polynomial 0x11B, with L_0 = 0x01.

---
 rtl/ipm_serial_masker.sv | 110 +++++++++++
 tb/tb_ipm_serial_masker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ipm_serial_masker.sv
// Serial inner-product masker: turns a 128-bit plaintext into 16 IPM-encoded
// bytes of v shares each, one byte per clock.
module ipm_serial_masker #(
  parameter int v = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [127:0]          plaintext,
  input  logic [v*8-1:0]        L,
  input  logic [(v-1)*8-1:0]    rnd,
  output logic                  rnd_req,
  output logic [16*v*8-1:0]     masked_out,
  output logic                  busy,
  output logic                  done
);

  localparam int GW = 8 * v;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MASK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [127:0]     pt_reg;
  logic [v*8-1:0]   l_reg;
  logic [7:0]       r0;
  logic [GW-1:0]    group;
  logic             unused_l0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // L_0 is fixed at 0x01 by contract, so it never enters the datapath.
  assign unused_l0 = ^l_reg[7:0];

  assign rnd_req = (state == S_MASK);

  always_comb begin
    r0 = pt_reg[{cnt, 3'b000} +: 8];
    for (int i = 1; i < v; i++) begin
      r0 = r0 ^ gf_mul(l_reg[8*i +: 8], rnd[8*(i-1) +: 8]);
    end
    group = {rnd, r0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pt_reg     <= '0;
      l_reg      <= '0;
      masked_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pt_reg <= plaintext;
            l_reg  <= L;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_MASK;
          end
        end
        S_MASK: begin
          for (int k = 0; k < 16; k++) begin
            if (cnt == 4'(k)) masked_out[k*GW +: GW] <= group;
          end
          if (cnt == 4'd15) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          // A start seen in the DONE cycle chains straight into the next run.
          if (start) begin
            pt_reg <= plaintext;
            l_reg  <= L;
            cnt    <= '0;
            state  <= S_MASK;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipm_serial_masker.sv
// Bench for ipm_serial_masker: directed vectors, multi-cycle corner sequences
// and randomized round trips against a polynomial-arithmetic reference.
module tb_ipm_serial_masker;

  localparam int V  = 3;
  localparam int GW = 8 * V;
  localparam int OW = 16 * GW;
  localparam int RW = (V - 1) * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [127:0]  plaintext = '0;
  logic [GW-1:0] L = '0;
  logic [RW-1:0] rnd = '0;
  logic          rnd_req;
  logic [OW-1:0] masked_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  logic [RW-1:0] rnd_seq [16];

  typedef struct {
    logic [7:0]    b0;
    logic [GW-1:0] l;
    logic [RW-1:0] r;
    logic [GW-1:0] g0;
  } tv_t;
  tv_t tv [5];

  ipm_serial_masker #(.v(V)) dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext), .L(L),
    .rnd(rnd), .rnd_req(rnd_req), .masked_out(masked_out), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction modulo 0x11B.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--) if (p[bit_i]) p = p ^ (16'h11B << (bit_i - 8));
    return p[7:0];
  endfunction

  function automatic logic [OW-1:0] model_mask(input logic [127:0] pt, input logic [GW-1:0] l);
    logic [OW-1:0] o;
    logic [7:0] s;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      s = pt[8*k +: 8];
      for (int i = 1; i < V; i++) s = s ^ gf_ref(l[8*i +: 8], rnd_seq[k][8*(i-1) +: 8]);
      o[k*GW +: GW] = {rnd_seq[k], s};
    end
    return o;
  endfunction

  function automatic logic [127:0] unmask(input logic [OW-1:0] m, input logic [GW-1:0] l);
    logic [127:0] p;
    logic [7:0] s;
    for (int k = 0; k < 16; k++) begin
      s = '0;
      for (int i = 0; i < V; i++) s = s ^ gf_ref(l[8*i +: 8], m[k*GW + 8*i +: 8]);
      p[8*k +: 8] = s;
    end
    return p;
  endfunction

  // One full operation; optional second start pulse at sample point restart_at.
  task automatic run_op(input string tag, input logic [127:0] pt, input logic [GW-1:0] l,
                        input int restart_at, input bit do_unmask);
    int nreq, ndone, dcyc;
    logic b17;
    logic [OW-1:0] exp;
    exp = model_mask(pt, l);
    nreq = 0; ndone = 0; dcyc = -1; b17 = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; plaintext = pt; L = l; rnd = rnd_seq[0];
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b0;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        L = GW'({$urandom, $urandom});
      end
      if (k == restart_at) begin start = 1'b1; plaintext = ~pt; end
      if (k == restart_at + 1) start = 1'b0;
      if (k < 16) rnd = rnd_seq[k];
      if (rnd_req) nreq++;
      if (done) begin ndone++; dcyc = k; end
      if (k == 17) b17 = busy;
    end
    check({tag, "_rnd_req_cycles"}, OW'(nreq), OW'(16));
    check({tag, "_done_count"}, OW'(ndone), OW'(1));
    check({tag, "_done_cycle"}, OW'(dcyc), OW'(16));
    check({tag, "_busy_after"}, OW'(b17), OW'(0));
    check({tag, "_masked_out"}, masked_out, exp);
    if (do_unmask) check({tag, "_round_trip"}, OW'(unmask(masked_out, l)), OW'(pt));
  endtask

  initial begin
    logic [127:0]  pt1, pt2;
    logic [GW-1:0] lr;
    logic [OW-1:0] e1, e2, mix;
    int nd, dc1, dc2;

    tv[0] = '{8'h53, 24'h020301, 16'h0000, 24'h000053};
    tv[1] = '{8'h53, 24'h020301, 16'h8001, 24'h80014B};
    tv[2] = '{8'h00, 24'h020301, 16'h0101, 24'h010101};
    tv[3] = '{8'h00, 24'h015701, 16'h0083, 24'h0083C1};
    tv[4] = '{8'hFF, 24'h005701, 16'h0013, 24'h001301};

    // Reset state
    #3;
    check("reset_masked_out", masked_out, '0);
    check("reset_busy", OW'(busy), '0);
    check("reset_done", OW'(done), '0);
    check("reset_rnd_req", OW'(rnd_req), '0);
    @(posedge clk); #1; rst = 1'b1;

    // Directed vectors
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 16; k++) rnd_seq[k] = tv[t].r;
      pt1 = {$urandom, $urandom, $urandom, $urandom};
      pt1[7:0] = tv[t].b0;
      run_op($sformatf("vec%0d", t), pt1, tv[t].l, -1, 1'b0);
      check($sformatf("vec%0d_group0", t), OW'(masked_out[GW-1:0]), OW'(tv[t].g0));
    end

    // Start while busy is ignored
    for (int k = 0; k < 16; k++) rnd_seq[k] = RW'($urandom);
    run_op("busy_start", {$urandom, $urandom, $urandom, $urandom}, 24'h1D2E01, 5, 1'b1);

    // Asynchronous reset mid-run
    @(posedge clk); #1;
    start = 1'b1; plaintext = {4{32'hA5A5_5A5A}}; L = 24'h020301;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_masked_out", masked_out, '0);
    check("midrst_busy", OW'(busy), '0);
    check("midrst_done", OW'(done), '0);
    check("midrst_rnd_req", OW'(rnd_req), '0);
    @(posedge clk); #1; rst = 1'b1;
    run_op("after_rst", {$urandom, $urandom, $urandom, $urandom}, 24'h8C4701, -1, 1'b1);

    // Back-to-back: second start presented during the DONE cycle
    for (int k = 0; k < 16; k++) rnd_seq[k] = RW'($urandom);
    pt1 = {$urandom, $urandom, $urandom, $urandom};
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    lr = {16'($urandom), 8'h01};
    e1 = model_mask(pt1, lr);
    e2 = model_mask(pt2, lr);
    mix = e1;
    mix[GW-1:0] = e2[GW-1:0];
    nd = 0; dc1 = -1; dc2 = -1;
    @(posedge clk); #1;
    start = 1'b1; plaintext = pt1; L = lr; rnd = rnd_seq[0];
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      if (k == 0) start = 1'b0;
      if (k < 16) rnd = rnd_seq[k];
      if (k >= 17 && k < 33) rnd = rnd_seq[k-17];
      if (k == 16) begin start = 1'b1; plaintext = pt2; end
      if (k == 17) begin
        start = 1'b0;
        check("b2b_busy_held", OW'(busy), OW'(1));
        check("b2b_result1_held", masked_out, e1);
      end
      if (k == 18) check("b2b_first_overwrite", masked_out, mix);
      if (done) begin
        nd++;
        if (nd == 1) dc1 = k; else dc2 = k;
      end
    end
    check("b2b_done_count", OW'(nd), OW'(2));
    check("b2b_done1_cycle", OW'(dc1), OW'(16));
    check("b2b_done2_cycle", OW'(dc2), OW'(33));
    check("b2b_result2", masked_out, e2);

    // Randomized round trips
    for (int n = 0; n < 100; n++) begin
      for (int k = 0; k < 16; k++) rnd_seq[k] = RW'({$urandom, $urandom});
      run_op($sformatf("rand%0d", n), {$urandom, $urandom, $urandom, $urandom},
             {RW'({$urandom, $urandom}), 8'h01}, -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
